ps2_kbd_ctrl: RTL

- Receives PS/2 keyboard frames in the system clock domain and checks each frame.
- Sequences multi-byte scan-code protocol (E0 extended prefix, F0 break prefix), suppresses typematic repeats and queues decoded key events in a small FIFO behind a valid/ready interface.
- Sits between the raw ps2_clk/ps2_data pins and display/ASCII consumers; replaces direct sampling on the ps2_clk edge.

---
 rtl/ps2_kbd_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronises the pins, checks frames, decodes E0/F0
// prefixes, suppresses typematic repeats and queues key events in a FWFT FIFO.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic [7:0] key_count,
  output logic [7:0] err_count,
  output logic       overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic fall;

  state_t     state, state_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic [7:0] shift_reg, shift_next;
  logic       parity_bit, parity_next;
  logic [WDW-1:0] wd_cnt;
  logic       frame_ok, frame_err, timeout;
  logic       byte_rdy;
  logic [7:0] rx_byte;

  logic       ext_flag, brk_flag;
  logic       held_valid;
  logic [7:0] held_code;
  logic       emit, emit_brk, make_evt;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, push, pop;
  logic [9:0]  head;

  // Pins idle high, so the synchronisers reset high to avoid a spurious fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    frame_ok     = 1'b0;
    frame_err    = 1'b0;
    timeout      = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s2) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {data_s2, shift_reg[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_next = data_s2;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_s2 && (^{shift_reg, parity_bit})) frame_ok = 1'b1;
          else frame_err = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && wd_cnt == WDW'(TIMEOUT_CYC)) begin
      state_next = IDLE;
      timeout    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
      wd_cnt     <= '0;
      byte_rdy   <= 1'b0;
      rx_byte    <= 8'd0;
      err_count  <= 8'd0;
    end else begin
      state      <= state_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      byte_rdy   <= frame_ok;
      if (frame_ok) rx_byte <= shift_reg;
      if (state == IDLE || fall) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WDW'(1);
      if ((frame_err || timeout) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_brk = 1'b0;
    make_evt = 1'b0;
    if (byte_rdy && rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
      if (brk_flag) begin
        emit     = 1'b1;
        emit_brk = 1'b1;
      end else if (!(held_valid && held_code == rx_byte)) begin
        emit     = 1'b1;
        make_evt = 1'b1;
      end
    end
  end

  // Prefix flags survive frame errors; they only clear on a non-prefix byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      held_valid <= 1'b0;
      held_code  <= 8'd0;
      key_count  <= 8'd0;
    end else if (byte_rdy) begin
      if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (brk_flag && held_valid && held_code == rx_byte) held_valid <= 1'b0;
        if (make_evt) begin
          held_code  <= rx_byte;
          held_valid <= 1'b1;
          key_count  <= key_count + 8'd1;
        end
      end
    end
  end

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = evt_valid && evt_ready;
  assign push = emit && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (emit && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rx_byte, emit_brk, ext_flag};
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? head[9:2] : 8'd0;
  assign evt_break = evt_valid ? head[1] : 1'b0;
  assign evt_ext   = evt_valid ? head[0] : 1'b0;

endmodule
